// File: rtl/fun.sv
// Four-input dual-rail Boolean evaluator: registered F = sum m(0,1,3,6,7,8,11,14,15) over {a,b,c,d}.
// Latency 1 cycle; out/rail_err update on every rising edge of clk, no combinational input-to-output path.
// No backpressure; a new sample is taken every cycle. Optional macro: FUN_RAIL_CHECK_EN (rail validation).
module fun (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic not_a,
   input  logic b,
   input  logic not_b,
   input  logic c,
   input  logic not_c,
   input  logic d,
   input  logic not_d,
   output logic out,
   output logic rail_err
);

   // Complement literals used by the SOP terms.
   logic w_na;
   logic w_nb;
   logic w_nc;
   logic w_nd;
   // Per-pair complementarity, ordered {a,b,c,d}.
   logic [3:0] w_pair_ok;
   // High when every rail pair may be trusted this cycle.
   logic w_all_ok;
   // Combinational function value ahead of the output register.
   logic w_f;

   logic r_out;
   logic r_rail_err;

`ifdef FUN_RAIL_CHECK_EN
   // Complemented literals come straight from the complement rails so that a
   // dual-rail source drives both polarities without local inversion.
   assign w_na = not_a;
   assign w_nb = not_b;
   assign w_nc = not_c;
   assign w_nd = not_d;

   // A pair is good only when its two rails disagree; 00 and 11 are both faults.
   assign w_pair_ok = {a ^ not_a, b ^ not_b, c ^ not_c, d ^ not_d};
   assign w_all_ok  = &w_pair_ok;
`else
   // Without rail checking the complement rails carry no information we use;
   // literals are derived from the true rails alone.
   assign w_na = ~a;
   assign w_nb = ~b;
   assign w_nc = ~c;
   assign w_nd = ~d;

   assign w_pair_ok = 4'b1111;
   assign w_all_ok  = 1'b1;

   // Complement rails are deliberately left unconnected to any logic.
   logic w_unused_rails;
   assign w_unused_rails = ^{not_a, not_b, not_c, not_d, w_pair_ok};
`endif

   // Minimal SOP: B.C + B'.C.D + B'.C'.D' + A'.B'.C'
   always_comb begin
      w_f = (b & c)
          | (w_nb & c & d)
          | (w_nb & w_nc & w_nd)
          | (w_na & w_nb & w_nc);
   end

   // Output register: capture F when all rails are valid, otherwise hold the
   // last good value and flag the fault; reset overrides any capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out      <= 1'b0;
         r_rail_err <= 1'b0;
      end else if (w_all_ok) begin
         r_out      <= w_f;
         r_rail_err <= 1'b0;
      end else begin
         r_out      <= r_out;
         r_rail_err <= 1'b1;
      end
   end

   assign out      = r_out;
   assign rail_err = r_rail_err;

endmodule

// File: tb/tb_fun.sv
// Self-checking bench for fun: scoreboard queue filled by stimulus, drained by a negedge monitor.
// Expected values come from a minterm lookup table plus a hold/flag rule for broken rail pairs.
// Runs directed cases from the test list and a randomized sweep with occasional rail faults.
module tb_fun;

   logic clk;
   logic rst_n;
   logic a, not_a, b, not_b, c, not_c, d, not_d;
   logic out;
   logic rail_err;

   fun u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .not_a    (not_a),
      .b        (b),
      .not_b    (not_b),
      .c        (c),
      .not_c    (not_c),
      .d        (d),
      .not_d    (not_d),
      .out      (out),
      .rail_err (rail_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Each entry is {expected out, expected rail_err} for one capture edge.
   logic [1:0] exp_q[$];

   // Reference state: what the outputs should hold after the latest edge.
   logic m_out = 1'b0;
   logic m_err = 1'b0;

`ifdef FUN_RAIL_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   function automatic logic f_ref(input logic [3:0] idx);
      logic [15:0] ones;
      ones = '0;
      foreach (ones[i]) begin
         if (i == 0 || i == 1 || i == 3 || i == 6 || i == 7 ||
             i == 8 || i == 11 || i == 14 || i == 15)
            ones[i] = 1'b1;
      end
      return ones[idx];
   endfunction

   task automatic check(input string name, input logic act, input logic req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
   endtask

   // Apply one sample on the falling edge, then advance the model on the rising edge.
   task automatic step(input logic [3:0] t, input logic [3:0] n);
      logic bad;
      @(negedge clk);
      {a, b, c, d} = t;
      {not_a, not_b, not_c, not_d} = n;
      @(posedge clk);
      bad = CHECK_EN && ((t ^ n) != 4'b1111);
      if (bad) begin
         m_err = 1'b1;
      end else begin
         m_out = f_ref(t);
         m_err = 1'b0;
      end
      exp_q.push_back({m_out, m_err});
   endtask

   // Monitor: the DUT presents a fresh result every cycle; compare it mid-cycle.
   always @(negedge clk) begin
      logic [1:0] e;
      if (rst_n && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("out", out, e[1]);
         check("rail_err", rail_err, e[0]);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] t, n;
      rst_n = 1'b0;
      {a, b, c, d} = 4'b0000;
      {not_a, not_b, not_c, not_d} = 4'b1111;
      #1;
      check("reset_out", out, 1'b0);
      check("reset_err", rail_err, 1'b0);

      // Release reset with valid 0000 presented.
      @(negedge clk);
      rst_n = 1'b1;

      // Exhaustive sweep of valid codes.
      for (int i = 0; i < 16; i++) step(4'(i), ~4'(i));

      // Asynchronous reset while out is high.
      step(4'b0111, 4'b1000);
      #2;
      check("pre_reset_out", out, m_out);
      rst_n = 1'b0;
      #1;
      check("async_reset_out", out, 1'b0);
      check("async_reset_err", rail_err, 1'b0);
      exp_q.delete();
      m_out = 1'b0;
      m_err = 1'b0;
      @(negedge clk);
      {a, b, c, d} = 4'b0000;
      {not_a, not_b, not_c, not_d} = 4'b1111;
      rst_n = 1'b1;
      @(posedge clk);
      m_out = f_ref(4'b0000);
      exp_q.push_back({m_out, m_err});

      // Single broken pair holds out, then recovery.
      step(4'b0001, 4'b1110);
      step(4'b1001, 4'b1110);   // a = not_a = 1
      step(4'b0010, 4'b1101);
      // Two pairs stuck at 00 together.
      step(4'b0111, 4'b1000);
      step(4'b0100, 4'b1000);   // c,not_c = 00 and d,not_d = 00
      step(4'b1011, 4'b0000);   // every complement rail low

      // Inputs wiggle between edges; outputs must not follow.
      step(4'b1110, 4'b0001);
      #2;
      {a, b, c, d} = 4'b0100;
      {not_a, not_b, not_c, not_d} = 4'b1011;
      #1;
      check("midcycle_out", out, m_out);
      check("midcycle_err", rail_err, m_err);
      {a, b, c, d} = 4'b1110;
      {not_a, not_b, not_c, not_d} = 4'b0001;
      step(4'b1110, 4'b0001);

      // Random sweep with occasional broken pairs.
      for (int k = 0; k < 300; k++) begin
         t = 4'($urandom);
         n = ~t;
         if ($urandom_range(0, 3) == 0) n = n ^ 4'($urandom_range(1, 15));
         step(t, n);
      end

      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d results left unchecked, expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
